// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, round constants and
// column-major slicing helpers used by the round datapath stages.
package aes_pkg;

  localparam int NR = 10;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:  v = 8'h01;
      4'd2:  v = 8'h02;
      4'd3:  v = 8'h04;
      4'd4:  v = 8'h08;
      4'd5:  v = 8'h10;
      4'd6:  v = 8'h20;
      4'd7:  v = 8'h40;
      4'd8:  v = 8'h80;
      4'd9:  v = 8'h1b;
      4'd10: v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Column c occupies bits [127-32c -: 32]; byte 0 is the top byte.
  function automatic logic [31:0] get_word(input logic [127:0] s, input int c);
    return s[127-32*c -: 32];
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by
// the affine transform, purely combinational.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1b);
    end
    return p;
  endfunction

  // x^254 is the inverse for nonzero x and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/add_round_key_sched.sv
// AddRoundKey stage with an on-the-fly AES-128 key schedule; walks
// rounds 0..NR per block and rewinds to the base key afterwards.
module add_round_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [3:0]   round_out,
  output logic         last_out
);

  logic [127:0] key_cur;
  logic [127:0] key_base;
  logic [3:0]   round;
  logic [127:0] key_next;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic         accept;
  logic         last_round;

  assign in_ready   = (!out_valid || out_ready) && !key_load;
  assign accept     = in_valid && in_ready;
  assign last_round = (round == 4'(NR));
  assign rot_w      = {key_cur[23:0], key_cur[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte (rot_w[31-8*i -: 8]),
      .out_byte(sub_w[31-8*i -: 8])
    );
  end

  always_comb begin
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    t  = sub_w ^ {rcon(round + 4'd1), 24'h000000};
    w0 = get_word(key_cur, 0) ^ t;
    w1 = get_word(key_cur, 1) ^ w0;
    w2 = get_word(key_cur, 2) ^ w1;
    w3 = get_word(key_cur, 3) ^ w2;
    key_next = {w0, w1, w2, w3};
  end

  // key_load only moves the key schedule; a pending output still drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_cur   <= '0;
      key_base  <= '0;
      round     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      round_out <= '0;
      last_out  <= 1'b0;
    end else begin
      if (key_load) begin
        key_cur  <= key_in;
        key_base <= key_in;
        round    <= '0;
      end else if (accept) begin
        if (last_round) begin
          key_cur <= key_base;
          round   <= '0;
        end else begin
          key_cur <= key_next;
          round   <= round + 4'd1;
        end
      end

      if (accept) begin
        data_out  <= data_in ^ key_cur;
        round_out <= round;
        last_out  <= last_round;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_round_key_sched.sv
// Randomized and directed bench for add_round_key_sched against a
// whole-schedule reference model built from the FIPS-197 expansion.
module tb_add_round_key_sched;

  logic         clk;
  logic         rst_n;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [3:0]   round_out;
  logic         last_out;

  add_round_key_sched #(.NR(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .key_in   (key_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .round_out(round_out),
    .last_out (last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sbox_tbl [0:255];
  logic [127:0] m_keys   [0:10];
  int           m_round;
  logic         m_ov;
  logic [127:0] m_data;
  logic [3:0]   m_rout;
  logic         m_last;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic check_output(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table via the generator-3 walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox_tbl[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
  endtask

  task automatic load_model_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_tbl[temp[31:24]], sbox_tbl[temp[23:16]],
                sbox_tbl[temp[15:8]], sbox_tbl[temp[7:0]]};
        temp = temp ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One clock: drive at negedge, check in_ready, step model at posedge, check outputs.
  task automatic apply_stimulus(input logic rstn, input logic kl, input logic [127:0] key,
                                input logic iv, input logic [127:0] din, input logic ordy);
    logic exp_ready;
    logic acc;
    rst_n     = rstn;
    key_load  = kl;
    key_in    = key;
    in_valid  = iv;
    data_in   = din;
    out_ready = ordy;
    #1;
    exp_ready = (!m_ov || ordy) && !kl;
    check_output("in_ready", {127'h0, in_ready}, {127'h0, exp_ready});
    @(posedge clk);
    if (!rstn) begin
      m_ov = 1'b0; m_data = '0; m_rout = '0; m_last = 1'b0; m_round = 0;
      load_model_key('0);
    end else begin
      acc = iv && exp_ready;
      if (acc) begin
        m_data = din ^ m_keys[m_round];
        m_rout = 4'(m_round);
        m_last = (m_round == 10);
      end
      if (kl) begin
        load_model_key(key);
        m_round = 0;
      end else if (acc) begin
        m_round = (m_round == 10) ? 0 : m_round + 1;
      end
      if (acc) m_ov = 1'b1;
      else if (ordy) m_ov = 1'b0;
    end
    @(negedge clk);
    check_output("out_valid", {127'h0, out_valid}, {127'h0, m_ov});
    check_output("data_out", data_out, m_data);
    check_output("round_out", {124'h0, round_out}, {124'h0, m_rout});
    check_output("last_out", {127'h0, last_out}, {127'h0, m_last});
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0;
    data_in = '0; out_ready = 1'b1;
    m_ov = 1'b0; m_data = '0; m_rout = '0; m_last = 1'b0; m_round = 0;
    build_sbox();
    load_model_key('0);
    @(negedge clk);

    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check_output("reset_data", data_out, '0);
    check_output("reset_valid", {127'h0, out_valid}, '0);

    // FIPS-197 key, zero states across a full block
    apply_stimulus(1'b1, 1'b1, KEY_A, 1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, 1'b1);
    check_output("r0_data", data_out, KEY_A);
    check_output("r0_round", {124'h0, round_out}, 128'd0);
    for (int r = 1; r <= 10; r++) begin
      apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, 1'b1);
      if (r == 1) check_output("r1_data", data_out, 128'ha0fafe1788542cb123a339392a6c7605);
    end
    check_output("r10_data", data_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_output("r10_last", {127'h0, last_out}, 128'd1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, 1'b1);
    check_output("wrap_data", data_out, KEY_A);
    check_output("wrap_round", {124'h0, round_out}, 128'd0);

    // Second key with nonzero state, then a 5-cycle output stall
    apply_stimulus(1'b1, 1'b1, KEY_B, 1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1);
    check_output("keyb_r0", data_out, 128'h00102030405060708090a0b0c0d0e0f0);
    for (int r = 1; r <= 3; r++) apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, 1'b1);
    for (int s = 0; s < 5; s++) apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, 1'b0);
    check_output("stall_round", {124'h0, round_out}, 128'd3);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, 1'b1);
    check_output("resume_round", {124'h0, round_out}, 128'd4);

    // key_load colliding with in_valid at round 5 position
    apply_stimulus(1'b1, 1'b1, KEY_A, 1'b1, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, 1'b1);
    check_output("reload_round", {124'h0, round_out}, 128'd0);
    check_output("reload_data", data_out, KEY_A);

    // Reset mid-block
    for (int r = 0; r < 3; r++) apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, 1'b1);
    apply_stimulus(1'b0, 1'b1, KEY_B, 1'b1, '0, 1'b1);
    check_output("midrst_data", data_out, '0);
    check_output("midrst_valid", {127'h0, out_valid}, '0);
    apply_stimulus(1'b1, 1'b1, KEY_B, 1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, 1'b1);
    check_output("postrst_data", data_out, KEY_B);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      apply_stimulus(($urandom_range(0, 149) != 0),
                     ($urandom_range(0, 24) == 0),
                     {$urandom, $urandom, $urandom, $urandom},
                     ($urandom_range(0, 3) != 0),
                     {$urandom, $urandom, $urandom, $urandom},
                     ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
